// File: rtl/pp_pipeline_accel_mat2axi_geom_proc_pkg.sv
// pp_mat2axi_geom_pkg: state encoding, stride sentinel and width helpers for the Mat2Axi geometry block
package pp_mat2axi_geom_pkg;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam logic [31:0] STRIDE_AUTO = 32'hFFFF_FFFF;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Row beat width: one bit of headroom over the byte count so the round-up add never overflows
   function automatic int rb_w(input int cols_w, input int pb);
      return cols_w + pb + 1;
   endfunction

   function automatic int tb_w(input int rows_w, input int cols_w, input int pb);
      return rows_w + rb_w(cols_w, pb);
   endfunction

endpackage

// File: rtl/pp_pipeline_accel_mat2axi_geom_proc_seq_mult.sv
// pp_mat2axi_seq_mult: shift-add multiplier, one B bit per cycle LSB first, fixed B_W cycles
module pp_mat2axi_seq_mult
   import pp_mat2axi_geom_pkg::*;
#(
   parameter int A_W = 17,
   parameter int B_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [A_W-1:0]     i_a,
   input  logic [B_W-1:0]     i_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [A_W+B_W-1:0] o_p
);

   localparam int P_W   = A_W + B_W;
   localparam int CNT_W = clog2(B_W + 1);

   logic [P_W-1:0]   r_a;
   logic [P_W-1:0]   r_acc;
   logic [B_W-1:0]   r_b;
   logic [CNT_W-1:0] r_cnt;
   logic [P_W-1:0]   w_sum;

   assign w_sum  = r_acc + (r_b[0] ? r_a : '0);
   assign o_busy = r_cnt != '0;
   assign o_done = r_cnt == CNT_W'(1);
   assign o_p    = w_sum;

   // Accumulate one partial product per cycle; o_p carries the final product during the last step
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_a   <= P_W'(i_a);
         r_b   <= i_b;
         r_acc <= '0;
         r_cnt <= CNT_W'(B_W);
      end else if (o_busy) begin
         r_acc <= w_sum;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pp_pipeline_accel_mat2axi_geom_proc.sv
// pp_pipeline_accel_mat2axi_geom_proc: per-frame Mat2Axi geometry resolve under ap_ctrl_chain
module pp_pipeline_accel_mat2axi_geom_proc
   import pp_mat2axi_geom_pkg::*;
#(
   parameter int COLS_W         = 16,
   parameter int ROWS_W         = 16,
   parameter int AXI_W          = 64,
   parameter int PIX_BYTES_LOG2 = 0
) (
   input  logic                                    ap_clk,
   input  logic                                    ap_rst,
   input  logic                                    ap_start,
   output logic                                    ap_ready,
   output logic                                    ap_done,
   input  logic                                    ap_continue,
   output logic                                    ap_idle,
   input  logic [31:0]                             stride,
   input  logic [COLS_W-1:0]                       cols,
   input  logic [ROWS_W-1:0]                       rows,
   output logic [COLS_W-1:0]                       stride_eff,
   output logic [COLS_W+PIX_BYTES_LOG2-1:0]        pitch_bytes,
   output logic [COLS_W+PIX_BYTES_LOG2:0]          row_beats,
   output logic [ROWS_W+COLS_W+PIX_BYTES_LOG2:0]   total_beats,
   output logic                                    err
);

   localparam int PB      = PIX_BYTES_LOG2;
   localparam int PIT_W   = COLS_W + PB;
   localparam int RB      = rb_w(COLS_W, PB);
   localparam int TB      = tb_w(ROWS_W, COLS_W, PB);
   localparam int AB_LOG2 = clog2(AXI_W / 8);
   localparam int SUM_W   = RB + AB_LOG2;

   state_t            r_state;
   state_t            w_next;
   logic              w_fin;
   logic              w_auto;
   logic              w_err;
   logic [COLS_W-1:0] w_seff;
   logic [PIT_W-1:0]  w_pitch;
   logic [SUM_W-1:0]  w_bsum;
   logic [RB-1:0]     w_rb;
   logic              w_mul_busy;
   logic              w_mul_done;
   logic [TB-1:0]     w_prod;
   logic [COLS_W-1:0] r_seff;
   logic [PIT_W-1:0]  r_pitch;
   logic [RB-1:0]     r_rb;
   logic              r_err;
   logic [COLS_W-1:0] r_o_seff;
   logic [PIT_W-1:0]  r_o_pitch;
   logic [RB-1:0]     r_o_rb;
   logic [TB-1:0]     r_o_tb;
   logic              r_o_err;

   assign w_auto  = stride == STRIDE_AUTO;
   assign w_err   = !w_auto && ((|stride[31:COLS_W]) || (stride[COLS_W-1:0] < cols));
   assign w_seff  = (w_auto || w_err) ? cols : stride[COLS_W-1:0];
   assign w_pitch = PIT_W'(w_seff) << PB;
   assign w_bsum  = (SUM_W'(cols) << PB) + SUM_W'(AXI_W / 8 - 1);
   assign w_rb    = RB'(w_bsum >> AB_LOG2);

   assign stride_eff  = r_o_seff;
   assign pitch_bytes = r_o_pitch;
   assign row_beats   = r_o_rb;
   assign total_beats = r_o_tb;
   assign err         = r_o_err;

   pp_mat2axi_seq_mult #(
      .A_W (RB),
      .B_W (ROWS_W)
   ) u_mult (
      .clk    (ap_clk),
      .rst    (ap_rst),
      .i_load (ap_ready),
      .i_a    (w_rb),
      .i_b    (rows),
      .o_busy (w_mul_busy),
      .o_done (w_mul_done),
      .o_p    (w_prod)
   );

   // State register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Handshake outputs and next state; an idle multiplier in CALC falls back to IDLE
   always_comb begin
      w_next   = r_state;
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      ap_idle  = 1'b0;
      w_fin    = 1'b0;
      case (r_state)
         S_IDLE: begin
            ap_ready = ap_start;
            ap_idle  = !ap_start;
            w_next   = ap_start ? S_CALC : S_IDLE;
         end
         S_CALC: begin
            w_fin  = w_mul_done;
            w_next = w_mul_done ? S_DONE : (w_mul_busy ? S_CALC : S_IDLE);
         end
         S_DONE: begin
            ap_done = 1'b1;
            w_next  = ap_continue ? S_IDLE : S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Capture the combinational stride/pitch/beat resolve at the accepted start
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_seff  <= '0;
         r_pitch <= '0;
         r_rb    <= '0;
         r_err   <= 1'b0;
      end else if (ap_ready) begin
         r_seff  <= w_seff;
         r_pitch <= w_pitch;
         r_rb    <= w_rb;
         r_err   <= w_err;
      end
   end

   // Publish all results together on entry to DONE so consumers never see a mixed frame
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_o_seff  <= '0;
         r_o_pitch <= '0;
         r_o_rb    <= '0;
         r_o_tb    <= '0;
         r_o_err   <= 1'b0;
      end else if (w_fin) begin
         r_o_seff  <= r_seff;
         r_o_pitch <= r_pitch;
         r_o_rb    <= r_rb;
         r_o_tb    <= w_prod;
         r_o_err   <= r_err;
      end
   end

endmodule

// File: tb/tb_pp_pipeline_accel_mat2axi_geom_proc.sv
// tb_pp_pipeline_accel_mat2axi_geom_proc: scoreboard bench driving a PB=0 and a PB=2 instance in lockstep
module tb_pp_pipeline_accel_mat2axi_geom_proc;

   typedef struct {
      longint seff;
      longint pitch;
      longint rb;
      longint tb;
      longint err;
   } geo_t;

   typedef struct {
      geo_t a;
      geo_t b;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        ap_start;
   logic        ap_continue;
   logic [31:0] stride;
   logic [15:0] cols;
   logic [15:0] rows;
   logic        rdy0, done0, idle0, err0;
   logic        rdy1, done1, idle1, err1;
   logic [15:0] seff0, pitch0, seff1;
   logic [16:0] rb0;
   logic [32:0] tb0;
   logic [17:0] pitch1;
   logic [18:0] rb1;
   logic [34:0] tb1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   cont_wait = 0;
   exp_t sb[$];
   exp_t held;
   exp_t zero_e;

   pp_pipeline_accel_mat2axi_geom_proc #(
      .COLS_W(16), .ROWS_W(16), .AXI_W(64), .PIX_BYTES_LOG2(0)
   ) u0 (
      .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_ready(rdy0), .ap_done(done0),
      .ap_continue(ap_continue), .ap_idle(idle0), .stride(stride), .cols(cols), .rows(rows),
      .stride_eff(seff0), .pitch_bytes(pitch0), .row_beats(rb0), .total_beats(tb0), .err(err0)
   );

   pp_pipeline_accel_mat2axi_geom_proc #(
      .COLS_W(16), .ROWS_W(16), .AXI_W(64), .PIX_BYTES_LOG2(2)
   ) u1 (
      .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_ready(rdy1), .ap_done(done1),
      .ap_continue(ap_continue), .ap_idle(idle1), .stride(stride), .cols(cols), .rows(rows),
      .stride_eff(seff1), .pitch_bytes(pitch1), .row_beats(rb1), .total_beats(tb1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic geo_t model(input logic [31:0] s, input longint c, input longint r, input int pb);
      geo_t   g;
      longint sv;
      longint bpp;
      sv  = longint'(s);
      bpp = longint'(1) << pb;
      g.err  = 0;
      g.seff = c;
      if (s != 32'hFFFF_FFFF) begin
         if (sv > 65535 || sv < c) g.err = 1;
         else                      g.seff = sv;
      end
      g.pitch = g.seff * bpp;
      g.rb    = (c * bpp + 7) / 8;
      g.tb    = r * g.rb;
      return g;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic run_job(input logic [31:0] s, input logic [15:0] c, input logic [15:0] r);
      exp_t e;
      bit   got;
      got = 1'b0;
      e.a = model(s, longint'(c), longint'(r), 0);
      e.b = model(s, longint'(c), longint'(r), 2);
      @(posedge clk);
      #1;
      stride   = s;
      cols     = c;
      rows     = r;
      ap_start = 1'b1;
      sb.push_back(e);
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         got = rdy0;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL start_timeout: got no ap_ready expected ap_ready within 300 cycles");
      end
      @(posedge clk);
      #1;
      ap_start = 1'b0;
      stride   = $urandom;
      cols     = 16'($urandom);
      rows     = 16'($urandom);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((sb.size() != 0 || done0) && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0 pending", sb.size());
      end
   endtask

   // Consumer: acknowledge ap_done after cont_wait extra DONE cycles
   initial begin
      int dcnt;
      dcnt = 0;
      ap_continue = 1'b0;
      forever begin
         @(negedge clk);
         if (done0) begin
            ap_continue = dcnt >= cont_wait;
            dcnt++;
         end else begin
            ap_continue = 1'b0;
            dcnt = 0;
         end
      end
   end

   // Monitor: pops on the first DONE cycle and checks held results every cycle
   initial begin
      int t_ready;
      bit busy;
      bit seen;
      t_ready = 0;
      busy = 1'b0;
      seen = 1'b0;
      held = zero_e;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
            seen = 1'b0;
            held = zero_e;
         end else begin
            if (seen && !done0) begin
               busy = 1'b0;
               seen = 1'b0;
            end
            if (rdy0) begin
               chk("ready_while_busy", 64'(busy), 0);
               busy = 1'b1;
               t_ready = cyc;
            end
            if (done0) begin
               if (!seen) begin
                  if (sb.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_done: got ap_done expected none at cycle %0d", cyc);
                  end else begin
                     held = sb.pop_front();
                     chk("latency", 64'(cyc - t_ready), 17);
                  end
                  seen = 1'b1;
               end
               chk("idle_in_done", 64'(idle0), 0);
            end
            chk("done1_match", 64'(done1), 64'(done0));
            chk("u0_seff", 64'(seff0), held.a.seff);
            chk("u0_pitch", 64'(pitch0), held.a.pitch);
            chk("u0_row_beats", 64'(rb0), held.a.rb);
            chk("u0_total", 64'(tb0), held.a.tb);
            chk("u0_err", 64'(err0), held.a.err);
            chk("u1_seff", 64'(seff1), held.b.seff);
            chk("u1_pitch", 64'(pitch1), held.b.pitch);
            chk("u1_row_beats", 64'(rb1), held.b.rb);
            chk("u1_total", 64'(tb1), held.b.tb);
            chk("u1_err", 64'(err1), held.b.err);
         end
      end
   end

   // Stimulus
   initial begin
      logic [31:0] s;
      logic [15:0] c;
      logic [15:0] r;
      int          k;
      rst      = 1'b1;
      ap_start = 1'b0;
      stride   = '0;
      cols     = '0;
      rows     = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(rdy0), 0);
      chk("rst_done", 64'(done0), 0);
      chk("rst_idle", 64'(idle0), 1);
      chk("rst_idle_u1", 64'(idle1), 1);

      cont_wait = 0;
      run_job(32'hFFFF_FFFF, 16'd1920, 16'd1080);
      run_job(32'd2048, 16'd1920, 16'd4);
      run_job(32'd1000, 16'd1920, 16'd5);
      run_job(32'h0001_0800, 16'd1920, 16'd3);
      run_job(32'hFFFF_FFFF, 16'd7, 16'd0);
      run_job(32'd5, 16'd0, 16'd9);
      run_job(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
      run_job(32'h0000_FFFF, 16'hFFFF, 16'd1);
      drain();

      cont_wait = 5;
      run_job(32'd4096, 16'd3000, 16'd77);
      run_job(32'hFFFF_FFFF, 16'd33, 16'd12);
      drain();
      cont_wait = 0;

      run_job(32'hFFFF_FFFF, 16'd640, 16'd480);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort_idle", 64'(idle0), 1);
      chk("abort_done", 64'(done0), 0);

      for (int i = 0; i < 40; i++) begin
         cont_wait = $urandom_range(0, 5);
         c = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         k = $urandom_range(0, 3);
         s = (k == 0) ? 32'hFFFF_FFFF :
             (k == 1) ? $urandom :
             (k == 2) ? 32'(c) + 32'($urandom_range(0, 100)) :
                        32'($urandom_range(0, 65535));
         k = $urandom_range(0, 5);
         r = (k == 0) ? 16'd0 : (k == 1) ? 16'hFFFF : 16'($urandom_range(1, 3000));
         run_job(s, c, r);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
